// File: rtl/apb_cmd_master_pkg.sv
// apb_cmd_master_pkg: shared state encoding, defaults and serial-controller register map
package apb_cmd_master_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;
  localparam int TIMEOUT_DEF = 256;
  localparam logic [7:0] REG_START = 8'h00;
  localparam logic [7:0] REG_BUSY = 8'h04;
  localparam logic [7:0] REG_DOUT = 8'h08;
  localparam logic [7:0] REG_DIN = 8'h0C;
  localparam logic [7:0] REG_WR = 8'h10;
  localparam logic [7:0] REG_CLKDIV = 8'h14;
  localparam logic [7:0] REG_NEGDEL = 8'h18;
endpackage

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command/response streams and APB3 bus of the command master
interface apb_cmd_master_if #(parameter int AW = 32, parameter int DW = 32);
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic psel, penable, pwrite, pready, pslverr;
  logic [DW-1:0] pwdata, prdata;
  modport master (
    input cmd_valid, cmd_addr, cmd_wdata, cmd_write, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, psel, penable, pwrite, pwdata
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_write, rsp_ready, prdata, pready, pslverr,
    input cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_cmd_master_wait_timer.sv
// apb_wait_timer: saturating count of pready wait cycles with limit compare
module apb_wait_timer #(
  parameter int TIMEOUT = 256,
  parameter int TW = 9
) (
  input logic clk,
  input logic rstn,
  input logic clr,
  input logic en,
  output logic expired
);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !(&cnt)) cnt <= cnt + TW'(1);
  assign expired = (TIMEOUT != 0) && (cnt == LIMIT);
endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into single APB3 transfers with bounded wait
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW = 9
) (
  input logic clk,
  input logic rstn,
  apb_cmd_master_if.master bus
);
  state_t state, state_nxt;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q, rdata_q;
  logic pwrite_q, err_q, to_q, expired, accept, done;
  assign accept = state == IDLE && bus.cmd_valid;
  assign done = state == ACCESS && (bus.pready || expired);
  apb_wait_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
    .clk(clk),
    .rstn(rstn),
    .clr(state == SETUP),
    .en(state == ACCESS && !bus.pready),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = bus.cmd_valid ? SETUP : IDLE;
      SETUP: state_nxt = ACCESS;
      ACCESS: state_nxt = (bus.pready || expired) ? RESP : ACCESS;
      RESP: state_nxt = bus.rsp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  // pready wins over an expiry on the same cycle
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      paddr_q <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      to_q <= 1'b0;
    end else if (accept) begin
      paddr_q <= bus.cmd_addr;
      pwdata_q <= bus.cmd_wdata;
      pwrite_q <= bus.cmd_write;
    end else if (done) begin
      rdata_q <= (bus.pready && !pwrite_q) ? bus.prdata : '0;
      err_q <= bus.pready ? bus.pslverr : 1'b1;
      to_q <= !bus.pready;
    end
  assign bus.cmd_ready = rstn && state == IDLE;
  assign bus.psel = state == SETUP || state == ACCESS;
  assign bus.penable = state == ACCESS;
  assign bus.rsp_valid = state == RESP;
  assign bus.paddr = paddr_q;
  assign bus.pwdata = pwdata_q;
  assign bus.pwrite = pwrite_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err = err_q;
  assign bus.rsp_timeout = to_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: table-driven transfers plus backpressure and mid-transfer reset sequences
module tb_apb_cmd_master;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic write;
    int waits;
    logic [31:0] prdata;
    logic slverr;
    logic [31:0] e_rdata;
    logic e_err;
    logic e_to;
    int e_lat;
    int e_acc;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  vec_t v[6];
  always #5 clk = ~clk;
  apb_cmd_master_if #(.AW(32), .DW(32)) bus ();
  apb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(8), .TW(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic run(input vec_t t);
    int cyc, nacc;
    cyc = 0;
    nacc = 0;
    bus.pready = 1'b0;
    bus.pslverr = t.slverr;
    bus.prdata = t.prdata;
    bus.cmd_addr = t.addr;
    bus.cmd_wdata = t.wdata;
    bus.cmd_write = t.write;
    bus.cmd_valid = 1'b1;
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    while (!bus.rsp_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        bus.cmd_valid = 1'b0;
        chk("setup_phase", 32'({bus.psel, bus.penable}), 32'b10);
      end
      if (bus.psel) begin
        chk("paddr", bus.paddr, t.addr);
        chk("pwdata", bus.pwdata, t.wdata);
        chk("pwrite", 32'(bus.pwrite), 32'(t.write));
      end
      if (bus.psel && bus.penable) nacc++;
      bus.pready = bus.psel && bus.penable && nacc == t.waits + 1;
    end
    bus.pready = 1'b0;
    chk("latency", 32'(cyc), 32'(t.e_lat));
    chk("penable_cycles", 32'(nacc), 32'(t.e_acc));
    chk("rsp_rdata", bus.rsp_rdata, t.e_rdata);
    chk("rsp_err", 32'(bus.rsp_err), 32'(t.e_err));
    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(t.e_to));
    chk("bus_released", 32'({bus.psel, bus.penable}), 32'b00);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_handshake", 32'({bus.rsp_valid, bus.cmd_ready}), 32'b01);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_bad);
    $fatal(1);
  end
  initial begin
    v[0] = '{32'h14, 32'h32, 1'b1, 0, 32'h7777_7777, 1'b0, 32'h0, 1'b0, 1'b0, 3, 1};
    v[1] = '{32'h0C, 32'h0, 1'b0, 3, 32'hA5A5_1234, 1'b0, 32'hA5A5_1234, 1'b0, 1'b0, 6, 4};
    v[2] = '{32'h40, 32'h0, 1'b0, 0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 3, 1};
    v[3] = '{32'h04, 32'h0, 1'b0, 99, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 1'b1, 10, 8};
    v[4] = '{32'h08, 32'h0, 1'b0, 7, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 10, 8};
    v[5] = '{32'h10, 32'h1, 1'b1, 2, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 1'b0, 5, 3};
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.cmd_write = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.prdata = '0;
    bus.pready = 1'b0;
    bus.pslverr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_ctrl", 32'({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}), 32'd0);
    chk("rst_paddr", bus.paddr, 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) run(v[i]);
    // response backpressure with a second command waiting and pready stuck high
    bus.pready = 1'b1;
    bus.pslverr = 1'b0;
    bus.prdata = 32'h0000_0001;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 32'h00;
    bus.cmd_wdata = 32'h1;
    bus.cmd_write = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_addr = 32'h04;
    bus.cmd_wdata = 32'h0;
    bus.cmd_write = 1'b0;
    chk("bp_setup", 32'({bus.psel, bus.penable}), 32'b10);
    @(posedge clk);
    #1;
    chk("bp_access", 32'({bus.psel, bus.penable}), 32'b11);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 32'({bus.rsp_valid, bus.cmd_ready, bus.psel}), 32'b100);
      chk("bp_rdata", bus.rsp_rdata, 32'd0);
      chk("bp_paddr", bus.paddr, 32'h00);
      if (i == 4) bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("bp_idle", 32'({bus.rsp_valid, bus.cmd_ready, bus.psel}), 32'b010);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    chk("bp2_setup", 32'({bus.psel, bus.penable}), 32'b10);
    chk("bp2_paddr", bus.paddr, 32'h04);
    chk("bp2_pwrite", 32'(bus.pwrite), 32'd0);
    @(posedge clk);
    #1;
    chk("bp2_access", 32'({bus.psel, bus.penable}), 32'b11);
    @(posedge clk);
    #1;
    chk("bp2_rsp", 32'({bus.rsp_valid, bus.rsp_err}), 32'b10);
    chk("bp2_rdata", bus.rsp_rdata, 32'h0000_0001);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    bus.pready = 1'b0;
    chk("bp2_done", 32'({bus.rsp_valid, bus.cmd_ready}), 32'b01);
    // asynchronous reset during an ACCESS wait state
    bus.cmd_addr = 32'h18;
    bus.cmd_write = 1'b0;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pre", 32'({bus.psel, bus.penable}), 32'b11);
    rstn = 1'b0;
    #1;
    chk("rst_mid", 32'({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_after", 32'({bus.cmd_ready, bus.psel, bus.rsp_valid}), 32'b100);
    run(v[1]);
    run(v[3]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
APB3 initiator that turns a simple valid/ready command stream into single APB transfers, then returns read data and status on a valid/ready response stream. It sits between a sequencer or CPU-side command source and APB register blocks such as the serial-controller register file. It lets hardware program Start/DataOut/WR/ClockDiv/NegDel and poll Busy/DataIn without a processor. It carries one transfer in flight at a time and has a bounded wait on pready.

Parameters:
AW, 32, APB address width
DW, 32, APB data width
TIMEOUT, 256, max ACCESS cycles waiting for pready before abort; 0 disables timeout
TW, 9, timeout counter width; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  clock
rstn  in  1  asynchronous reset, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_addr  in  AW  target address
cmd_wdata  in  DW  write data
cmd_write  in  1  1=write, 0=read
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DW  read data; 0 for writes and timeouts
rsp_err  out  1  pslverr sampled, or timeout
rsp_timeout  out  1  transfer aborted by timeout
paddr  out  AW  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DW  APB write data
prdata  in  DW  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error

Behaviour:
- Reset (async, rstn=0): state=IDLE. psel, penable, pwrite, rsp_valid, rsp_err and rsp_timeout are 0. paddr, pwdata and rsp_rdata are 0. Timeout counter is 0. cmd_ready=0 while rstn=0.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1 (combinational from state). On cmd_valid, register the address, data and direction onto paddr/pwdata/pwrite, set psel=1, and go to SETUP. No other state accepts a command.
- SETUP: lasts exactly one cycle with psel=1, penable=0. Then go to ACCESS with penable=1 and the timeout counter cleared.
- ACCESS: psel=1, penable=1. pready is sampled only in this state; pready high in IDLE or SETUP is ignored, because some slaves hold pready high permanently.
  - pready=1: capture rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, rsp_timeout = 0. Deassert psel and penable. Go to RESP.
  - pready=0 and TIMEOUT!=0: increment the counter. When counter == TIMEOUT-1 while pready=0, abort: psel/penable=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1, go to RESP.
  - pready=1 on the same cycle the counter hits its limit: normal completion wins.
- RESP: rsp_valid=1, and all rsp_* outputs are stable until handshake. On rsp_ready, rsp_valid=0 and go to IDLE. The next command is accepted at the earliest one cycle later.
- paddr, pwrite and pwdata hold their values after a transfer until the next command is accepted. They never change while psel=1.
- Latency: cmd accept (cycle 0) -> SETUP (1) -> ACCESS (2). With zero wait states, rsp_valid is asserted in cycle 3. Each wait state adds 1 cycle.
- Throughput: with rsp_ready tied 1, one transfer per 4 cycles.
- Reset mid-transfer: the bus is dropped immediately (psel=0, penable=0) and no response is produced.
- Widths: no arithmetic on data. The counter saturates and cannot wrap.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3);
  - default TIMEOUT;
  - register offsets of the serial-controller block: START=8'h00, BUSY=8'h04, DOUT=8'h08, DIN=8'h0C, WR=8'h10, CLKDIV=8'h14, NEGDEL=8'h18.
- One sub-module, apb_wait_timer: clear, enable, TIMEOUT compare, expired flag. The FSM and datapath stay in apb_cmd_master.

Test Plan:
- Write, zero wait: cmd addr=0x14, wdata=0x0000_0032, write=1. Slave pready=1 in ACCESS.
  - Required: psel rises cycle 1; penable rises cycle 2 only; paddr/pwdata stable over both cycles.
  - Required: rsp_valid in cycle 3 with rsp_rdata=0, rsp_err=0.
- Read with 3 wait states: addr=0x0C, slave returns prdata=0xA5A5_1234 on the 4th ACCESS cycle.
  - Required: rsp_rdata=0xA5A5_1234, rsp_valid in cycle 6, penable high for exactly 4 cycles.
- Slave error: read addr=0x40, pslverr=1 with pready=1.
  - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
- Timeout: TIMEOUT=8, pready stuck 0.
  - Required: after 8 ACCESS cycles psel/penable=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with pready=1 exactly on the 8th cycle -> normal completion, rsp_timeout=0.
- Backpressure and sticky pready: rsp_ready held 0 for 5 cycles while a second cmd_valid is pending. Slave pready held constantly 1.
  - Required: cmd_ready=0 and the response holds until the rsp handshake.
  - Required: the second transfer starts only after return to IDLE, and SETUP still lasts 1 cycle.
- Reset mid-ACCESS: rstn pulsed low during a wait state.
  - Required: psel/penable/rsp_valid=0 immediately; after release the FSM is in IDLE and the next command completes normally.
